pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: forwarding selects, load-use stall,
// branch flush and memory-wait freeze, with saturating stall/flush event counters.
//
// state   | meaning
// RUN     | normal issue; forwarding, load-use stall and branch flush are active
// LDSTALL | single bubble cycle after a load-use stall; load-use is ignored
// MEMWAIT | data memory busy; every stage frozen, forwarding held, branches deferred
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic [4:0]       idex_rs,
  input  logic [4:0]       idex_rt,
  input  logic             idex_memread,
  input  logic [4:0]       exmem_rd,
  input  logic [4:0]       memwb_rd,
  input  logic             exmem_regwrite,
  input  logic             memwb_regwrite,
  input  logic             branch_taken,
  input  logic             mem_busy,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LDSTALL = 2'b01,
    MEMWAIT = 2'b10
  } state_t;

  state_t     st_q;
  logic       pending_q;
  logic [1:0] hold_a_q, hold_b_q;
  logic [1:0] fwd_a, fwd_b;
  logic       luh, in_memwait, do_flush, do_stall;

  always_comb begin
    fwd_a = 2'b00;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == idex_rs)
      fwd_a = 2'b10;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == idex_rs)
      fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (exmem_regwrite && exmem_rd != 5'd0 && exmem_rd == idex_rt)
      fwd_b = 2'b10;
    else if (memwb_regwrite && memwb_rd != 5'd0 && memwb_rd == idex_rt)
      fwd_b = 2'b01;
  end

  assign luh        = idex_memread && idex_rt != 5'd0 &&
                      (idex_rt == ifid_rs || idex_rt == ifid_rt);
  assign in_memwait = (st_q == MEMWAIT);
  // A deferred branch only exists in the first RUN cycle after MEMWAIT.
  assign do_flush   = !in_memwait && !mem_busy && (branch_taken || pending_q);
  assign do_stall   = (st_q == RUN) && !mem_busy && !do_flush && luh;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    if (in_memwait) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_write = 1'b0;
    end else if (do_flush) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (do_stall) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign forwardA = in_memwait ? hold_a_q : fwd_a;
  assign forwardB = in_memwait ? hold_b_q : fwd_b;
  assign state    = st_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q      <= RUN;
      pending_q <= 1'b0;
      hold_a_q  <= 2'b00;
      hold_b_q  <= 2'b00;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (mem_busy)
        st_q <= MEMWAIT;
      else if (do_stall)
        st_q <= LDSTALL;
      else
        st_q <= RUN;

      if (do_flush)
        pending_q <= 1'b0;
      else if (branch_taken && (mem_busy || in_memwait))
        pending_q <= 1'b1;

      // Operand selects are frozen at the moment the pipeline stops.
      if (!in_memwait && mem_busy) begin
        hold_a_q <= fwd_a;
        hold_b_q <= fwd_b;
      end

      if (do_stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (do_flush && flush_cnt != '1)
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected control words and counter values
// go through a scoreboard queue and are compared with immediate assertions.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, exmem_rd, memwb_rd;
  logic idex_memread, exmem_regwrite, memwb_regwrite, branch_taken, mem_busy;

  logic [1:0]  forwardA, forwardB, state;
  logic        pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush;
  logic [15:0] stall_cnt, flush_cnt;

  logic [1:0]  forwardA4, forwardB4, state4;
  logic        pc_write4, ifid_write4, idex_write4, exmem_write4, ifid_flush4, idex_flush4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_dut (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_memread(idex_memread), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .forwardA(forwardA), .forwardB(forwardB),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .idex_rs(idex_rs), .idex_rt(idex_rt),
    .idex_memread(idex_memread), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .forwardA(forwardA4), .forwardB(forwardB4),
    .pc_write(pc_write4), .ifid_write(ifid_write4), .idex_write(idex_write4),
    .exmem_write(exmem_write4), .ifid_flush(ifid_flush4), .idex_flush(idex_flush4),
    .state(state4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  logic [11:0] obs, obs4;
  assign obs  = {forwardA, forwardB, pc_write, ifid_write, idex_write, exmem_write,
                 ifid_flush, idex_flush, state};
  assign obs4 = {forwardA4, forwardB4, pc_write4, ifid_write4, idex_write4, exmem_write4,
                 ifid_flush4, idex_flush4, state4};

  localparam logic [3:0] EN_ALL = 4'b1111, EN_STALL = 4'b0011, EN_NONE = 4'b0000;
  localparam logic [1:0] FL_NONE = 2'b00, FL_IDEX = 2'b01, FL_BOTH = 2'b11;
  localparam logic [1:0] S_RUN = 2'b00, S_LD = 2'b01, S_MW = 2'b10;

  typedef struct {
    string       tag;
    logic [11:0] ctl;
    logic [15:0] st;
    logic [15:0] fl;
    logic [3:0]  st4;
    logic [3:0]  fl4;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int model_stall = 0;
  int model_flush = 0;

  function automatic logic [11:0] mk(logic [1:0] fa, logic [1:0] fb, logic [3:0] en,
                                     logic [1:0] fl, logic [1:0] st);
    return {fa, fb, en, fl, st};
  endfunction

  function automatic logic [3:0] sat4(int v);
    return (v > 15) ? 4'hf : 4'(v);
  endfunction

  function automatic logic [15:0] sat16(int v);
    return (v > 65535) ? 16'hffff : 16'(v);
  endfunction

  task automatic check_now(string tag, logic [11:0] ectl, bit chk);
    exp_t e, g;
    e.tag = tag; e.ctl = ectl; e.chk = chk;
    e.st = sat16(model_stall); e.fl = sat16(model_flush);
    e.st4 = sat4(model_stall); e.fl4 = sat4(model_flush);
    sb.push_back(e);
    g = sb.pop_front();
    if (g.chk) begin
      checks++;
      assert (obs === g.ctl) else begin
        errors++;
        $error("FAIL %s ctl observed=%h expected=%h", g.tag, obs, g.ctl);
      end
      checks++;
      assert (obs4 === g.ctl) else begin
        errors++;
        $error("FAIL %s ctl4 observed=%h expected=%h", g.tag, obs4, g.ctl);
      end
    end
    checks++;
    assert (stall_cnt === g.st) else begin
      errors++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", g.tag, stall_cnt, g.st);
    end
    checks++;
    assert (flush_cnt === g.fl) else begin
      errors++;
      $error("FAIL %s flush_cnt observed=%0d expected=%0d", g.tag, flush_cnt, g.fl);
    end
    checks++;
    assert (stall_cnt4 === g.st4) else begin
      errors++;
      $error("FAIL %s stall_cnt4 observed=%0d expected=%0d", g.tag, stall_cnt4, g.st4);
    end
    checks++;
    assert (flush_cnt4 === g.fl4) else begin
      errors++;
      $error("FAIL %s flush_cnt4 observed=%0d expected=%0d", g.tag, flush_cnt4, g.fl4);
    end
  endtask

  // Inputs are already applied; check mid-cycle, then credit this cycle's events.
  task automatic cyc(string tag, logic [11:0] ectl, int dst, int dfl, bit chk = 1'b1);
    @(negedge clk);
    check_now(tag, ectl, chk);
    model_stall += dst;
    model_flush += dfl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ifid_rs = 0; ifid_rt = 0; idex_rs = 0; idex_rt = 0; exmem_rd = 0; memwb_rd = 0;
    idex_memread = 0; exmem_regwrite = 0; memwb_regwrite = 0;
    branch_taken = 0; mem_busy = 0;

    @(negedge clk);
    check_now("reset", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc("idle", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);

    // forwarding priority and r0 exclusion
    exmem_rd = 5; memwb_rd = 5; exmem_regwrite = 1; memwb_regwrite = 1; idex_rs = 5; idex_rt = 0;
    cyc("fwd_exmem_wins", mk(2'b10, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);
    exmem_regwrite = 0;
    cyc("fwd_memwb", mk(2'b01, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);
    exmem_regwrite = 1; memwb_rd = 7; idex_rt = 7;
    cyc("fwd_both", mk(2'b10, 2'b01, EN_ALL, FL_NONE, S_RUN), 0, 0);
    exmem_rd = 0; memwb_rd = 0; idex_rs = 0; idex_rt = 0;
    cyc("fwd_r0", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);
    exmem_regwrite = 0; memwb_regwrite = 0;

    // load-use stall, then one LDSTALL cycle ignoring the still-present hazard
    idex_memread = 1; idex_rt = 8; ifid_rt = 8;
    cyc("luh_stall", mk(2'b00, 2'b00, EN_STALL, FL_IDEX, S_RUN), 1, 0);
    cyc("ldstall", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_LD), 0, 0);
    idex_memread = 0;
    cyc("after_ld", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);

    // branch overrides load-use; branch inside LDSTALL also flushes
    idex_memread = 1; branch_taken = 1;
    cyc("luh_branch", mk(2'b00, 2'b00, EN_ALL, FL_BOTH, S_RUN), 0, 1);
    branch_taken = 0;
    cyc("luh_stall2", mk(2'b00, 2'b00, EN_STALL, FL_IDEX, S_RUN), 1, 0);
    branch_taken = 1;
    cyc("ld_branch", mk(2'b00, 2'b00, EN_ALL, FL_BOTH, S_LD), 0, 1);
    branch_taken = 0; idex_memread = 0;
    cyc("after_ldbr", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);

    // 3-cycle mem_busy with a branch in the second; forwarding held across the wait
    idex_rs = 5; exmem_rd = 5; exmem_regwrite = 1; mem_busy = 1;
    cyc("mb_rise", mk(2'b10, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);
    exmem_rd = 9; branch_taken = 1;
    cyc("mw1", mk(2'b10, 2'b00, EN_NONE, FL_NONE, S_MW), 0, 0);
    branch_taken = 0;
    cyc("mw2", mk(2'b10, 2'b00, EN_NONE, FL_NONE, S_MW), 0, 0);
    mem_busy = 0;
    cyc("mw3", mk(2'b10, 2'b00, EN_NONE, FL_NONE, S_MW), 0, 0);
    cyc("mw_exit_flush", mk(2'b00, 2'b00, EN_ALL, FL_BOTH, S_RUN), 0, 1);
    cyc("post_exit", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);
    idex_rs = 0; exmem_rd = 0; exmem_regwrite = 0;

    // mem_busy together with load-use: wait wins, hazard re-evaluated on exit
    idex_memread = 1; mem_busy = 1;
    cyc("mb_luh", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0, 1'b0);
    mem_busy = 0;
    cyc("mb_luh_wait", mk(2'b00, 2'b00, EN_NONE, FL_NONE, S_MW), 0, 0);
    cyc("luh_reeval", mk(2'b00, 2'b00, EN_STALL, FL_IDEX, S_RUN), 1, 0);
    cyc("ldstall3", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_LD), 0, 0);
    idex_memread = 0;
    cyc("after_ld3", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);

    // 20 more stalls via the rs match; the 4-bit counter must stop at 15
    ifid_rt = 0; ifid_rs = 8; idex_memread = 1;
    for (int i = 0; i < 20; i++) begin
      cyc("sat_stall", mk(2'b00, 2'b00, EN_STALL, FL_IDEX, S_RUN), 1, 0);
      cyc("sat_ld", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_LD), 0, 0);
    end
    idex_memread = 0;
    cyc("sat_end", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);

    // asynchronous reset in the middle of LDSTALL
    idex_memread = 1;
    cyc("pre_rst_stall", mk(2'b00, 2'b00, EN_STALL, FL_IDEX, S_RUN), 1, 0);
    #2;
    reset = 1'b1; idex_memread = 0;
    model_stall = 0; model_flush = 0;
    #1;
    check_now("rst_ldstall", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // asynchronous reset in MEMWAIT with a deferred flush pending
    mem_busy = 1; branch_taken = 1;
    cyc("mb_br_rise", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);
    branch_taken = 0;
    cyc("mw_pend", mk(2'b00, 2'b00, EN_NONE, FL_NONE, S_MW), 0, 0);
    #2;
    reset = 1'b1; mem_busy = 0;
    #1;
    check_now("rst_mw", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 1'b1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc("post_rst1", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);
    cyc("post_rst2", mk(2'b00, 2'b00, EN_ALL, FL_NONE, S_RUN), 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
